md_ctrl: RTL and testbench

Multiply/divide sequencer for the five-stage MIPS pipeline, instantiated in the E stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo from E and computes results with a fixed multi-cycle latency. Results are held in architectural HI/LO registers. It raises a stall request that the D-stage hazard logic ORs into its stall, so no HI/LO-touching instruction leaves D while the unit is starting or busy.

---
 rtl/md_if.sv | 17 +
 rtl/md_ctrl.sv | 118 +++++++++++
 tb/tb_md_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/md_if.sv
// E-stage multiply/divide bus between the pipeline (master) and md_ctrl (slave).
interface md_if;
  logic        E_en;
  logic [2:0]  E_md_op;
  logic [31:0] E_a;
  logic [31:0] E_b;
  logic        D_is_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output E_en, E_md_op, E_a, E_b, D_is_md,
                  input  busy, md_stall, hi, lo);
  modport slave  (input  E_en, E_md_op, E_a, E_b, D_is_md,
                  output busy, md_stall, hi, lo);
endinterface

// File: rtl/md_ctrl.sv
// Multi-cycle MIPS HI/LO multiply/divide sequencer for the E stage.
// Optional MD_DIV_ZERO_KEEP_EN: divide-by-zero leaves HI/LO unchanged.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  rst_n,
  md_if.slave   md
);
  typedef enum logic [2:0] {
    OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
    OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6, OP_RSVD = 3'd7
  } md_op_e;

  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, p_hi_q, p_hi_d, p_lo_q, p_lo_d;

  md_op_e      op;
  logic        busy, start, div_zero;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a, b, b_safe, mag_a, mag_b, q_m, r_m, q_u, r_u;
  logic [31:0] res_hi, res_lo;

  assign op       = md_op_e'(md.E_md_op);
  assign a        = md.E_a;
  assign b        = md.E_b;
  assign busy     = (cnt_q != 4'd0);
  assign start    = md.E_en && !busy &&
                    (op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU);
  assign div_zero = (b == 32'd0);

  // Divisor forced non-zero so the datapath never produces X; the zero case
  // is selected separately below.
  assign b_safe = div_zero ? 32'd1 : b;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign q_u    = a / b_safe;
  assign r_u    = a % b_safe;

  // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow case and
  // gives truncation toward zero with the remainder following the dividend.
  assign mag_a = a[31] ? (32'd0 - a) : a;
  assign mag_b = b[31] ? (32'd0 - b) : (div_zero ? 32'd1 : b);
  assign q_m   = mag_a / mag_b;
  assign r_m   = mag_a % mag_b;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_lo = (a[31] ^ b[31]) ? (32'd0 - q_m) : q_m;
        res_hi = a[31] ? (32'd0 - r_m) : r_m;
      end
      OP_DIVU: begin
        res_lo = q_u;
        res_hi = r_u;
      end
      default: ;
    endcase
    if ((op == OP_DIV || op == OP_DIVU) && div_zero) begin
`ifdef MD_DIV_ZERO_KEEP_EN
      res_hi = hi_q;
      res_lo = lo_q;
`else
      res_hi = a;
      res_lo = 32'hFFFF_FFFF;
`endif
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    p_hi_d = p_hi_q;
    p_lo_d = p_lo_q;
    if (start) begin
      p_hi_d = res_hi;
      p_lo_d = res_lo;
      cnt_d  = (op == OP_MULT || op == OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
    end else if (busy) begin
      // Any op arriving while busy is dropped; only the countdown advances.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        hi_d = p_hi_q;
        lo_d = p_lo_q;
      end
    end else if (md.E_en) begin
      if (op == OP_MTHI) hi_d = a;
      if (op == OP_MTLO) lo_d = a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 4'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      p_hi_q <= 32'd0;
      p_lo_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      p_hi_q <= p_hi_d;
      p_lo_q <= p_lo_d;
    end
  end

  assign md.busy     = busy;
  assign md.md_stall = md.D_is_md && (busy || start);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
endmodule

// File: tb/tb_md_ctrl.sv
// Directed vector bench for md_ctrl: table of ops plus reset/ignore sequences.
module tb_md_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  md_if bus ();
  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .rst_n(rst_n), .md(bus));

  typedef struct {
    logic        en;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t tbl[15];
  int checks = 0;
  int errors = 0;
  logic [31:0] prev_hi, prev_lo;
  int n;

`ifdef MD_DIV_ZERO_KEEP_EN
  localparam logic [31:0] DZ1_HI = 32'h0000_0000, DZ1_LO = 32'h8000_0000;
  localparam logic [31:0] DZ2_HI = 32'h3FFF_FFFF, DZ2_LO = 32'h0000_0001;
`else
  localparam logic [31:0] DZ1_HI = 32'h0000_1234, DZ1_LO = 32'hFFFF_FFFF;
  localparam logic [31:0] DZ2_HI = 32'hFFFF_FFFB, DZ2_LO = 32'hFFFF_FFFF;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.E_en    = en;
    bus.E_md_op = op;
    bus.E_a     = a;
    bus.E_b     = b;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    tbl[1]  = '{1'b1, 3'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5};
    tbl[2]  = '{1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    tbl[3]  = '{1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    tbl[4]  = '{1'b1, 3'd4, 32'h0000_1234, 32'd0,        DZ1_HI,        DZ1_LO,        10};
    tbl[5]  = '{1'b1, 3'd6, 32'hA5A5_A5A5, 32'd0,        DZ1_HI,        32'hA5A5_A5A5, 0};
    tbl[6]  = '{1'b1, 3'd5, 32'h0BAD_F00D, 32'd0,        32'h0BAD_F00D, 32'hA5A5_A5A5, 0};
    tbl[7]  = '{1'b1, 3'd4, 32'd100,       32'd7,        32'd2,         32'd14,        10};
    tbl[8]  = '{1'b1, 3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
    tbl[9]  = '{1'b1, 3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
    tbl[10] = '{1'b1, 3'd3, 32'hFFFF_FFFB, 32'd0,        DZ2_HI,        DZ2_LO,        10};
    tbl[11] = '{1'b1, 3'd7, 32'd5,         32'd5,        DZ2_HI,        DZ2_LO,        0};
    tbl[12] = '{1'b0, 3'd1, 32'd5,         32'd5,        DZ2_HI,        DZ2_LO,        0};
    tbl[13] = '{1'b1, 3'd2, 32'h0001_0000, 32'h0001_0000, 32'd1,        32'd0,         5};
    tbl[14] = '{1'b1, 3'd6, 32'h1357_9BDF, 32'd0,        32'd1,         32'h1357_9BDF, 0};

    rst_n = 1'b0;
    bus.D_is_md = 1'b1;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    #12;
    chk("reset_hi", bus.hi, 32'd0);
    chk("reset_lo", bus.lo, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_stall", {31'd0, bus.md_stall}, 32'd0);
    rst_n = 1'b1;
    prev_hi = 32'd0;
    prev_lo = 32'd0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].en, tbl[i].op, tbl[i].a, tbl[i].b);
      #1;
      chk($sformatf("v%0d_start_stall", i), {31'd0, bus.md_stall}, {31'd0, tbl[i].cyc > 0});
      @(posedge clk); #1;
      drive(1'b0, 3'd0, 32'd0, 32'd0);
      n = 0;
      while (bus.busy && n < 40) begin
        chk($sformatf("v%0d_busy_hi", i), bus.hi, prev_hi);
        chk($sformatf("v%0d_busy_lo", i), bus.lo, prev_lo);
        chk($sformatf("v%0d_busy_stall", i), {31'd0, bus.md_stall}, 32'd1);
        n++;
        @(posedge clk); #1;
      end
      chk($sformatf("v%0d_busy_cycles", i), n, tbl[i].cyc);
      chk($sformatf("v%0d_hi", i), bus.hi, tbl[i].hi);
      chk($sformatf("v%0d_lo", i), bus.lo, tbl[i].lo);
      chk($sformatf("v%0d_idle_stall", i), {31'd0, bus.md_stall}, 32'd0);
      prev_hi = tbl[i].hi;
      prev_lo = tbl[i].lo;
    end

    // Ops forced into E while busy must be ignored.
    @(negedge clk);
    drive(1'b1, 3'd1, 32'd3, 32'd5);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    n = 0;
    while (bus.busy && n < 40) begin
      if (n == 1) drive(1'b1, 3'd3, 32'd1, 32'd1);
      else if (n == 2) drive(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0);
      else if (n == 3) drive(1'b1, 3'd1, 32'd9, 32'd9);
      else drive(1'b0, 3'd0, 32'd0, 32'd0);
      n++;
      @(posedge clk); #1;
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    chk("ignore_busy_cycles", n, 5);
    chk("ignore_hi", bus.hi, 32'd0);
    chk("ignore_lo", bus.lo, 32'd15);
    @(posedge clk); #1;
    chk("ignore_after_busy", {31'd0, bus.busy}, 32'd0);
    chk("ignore_after_lo", bus.lo, 32'd15);

    // Reset in busy cycle 3 of a div: immediate clear, no later commit.
    @(negedge clk);
    drive(1'b1, 3'd4, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hi", bus.hi, 32'd0);
    chk("rst_mid_lo", bus.lo, 32'd0);
    chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 14; i++) @(posedge clk);
    #1;
    chk("rst_nocommit_hi", bus.hi, 32'd0);
    chk("rst_nocommit_lo", bus.lo, 32'd0);
    chk("rst_nocommit_busy", {31'd0, bus.busy}, 32'd0);

    // Reset released mid-cycle with a mult waiting: accepted at the next edge.
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b1, 3'd1, 32'd6, 32'd7);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    chk("rel_start_busy", {31'd0, bus.busy}, 32'd1);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk("rel_busy_cycles", n, 5);
    chk("rel_hi", bus.hi, 32'd0);
    chk("rel_lo", bus.lo, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
